// File: rtl/pipelined_add_sub.sv
// Pipelined two's-complement adder/subtractor; the carry chain is cut into
// STAGES equal segments, one register boundary per segment (latency STAGES).
// Backpressure: stall = out_valid && !out_ready freezes every stage; in_ready = !stall.
//
// Ports:
//   clk, rst_n            rising-edge clock, asynchronous active-low reset
//   in_valid / in_ready   operand handshake (a, b, sub; sub=1 selects a-b)
//   out_valid / out_ready result handshake (sum, cout, overflow)
//   cout                  carry out of the MSB (subtract: 1 = no borrow)
//   overflow              signed overflow of the result
//
// Build option: define ADDSUB_SATURATE_EN to clamp sum to the most positive /
// most negative value on signed overflow (applied in the final stage, no extra
// latency). Left undefined, sum wraps modulo 2^WIDTH.

module pipelined_add_sub #(
   parameter int WIDTH  = 32,
   parameter int STAGES = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             overflow
);

   localparam int SEG = WIDTH / STAGES;

   if ((STAGES < 1) || (STAGES > WIDTH) || ((WIDTH % STAGES) != 0)) begin : g_param_check
      $error("pipelined_add_sub: WIDTH must be a multiple of STAGES and 1 <= STAGES <= WIDTH");
   end

   logic             stall;
   logic             out_valid_q;
   logic [WIDTH-1:0] sum_q;
   logic             cout_q;
   logic             overflow_q;

   // Values presented by the last adder segment, before the output register.
   logic             last_vld;
   logic             last_c;
   logic [WIDTH-1:0] last_sum;
   logic             last_a_msb;
   logic             last_bp_msb;

   logic             overflow_d;
   logic [WIDTH-1:0] sum_d;

   // A held result blocks the whole pipe; bubbles are not squeezed out, which
   // keeps in_ready a single gate away from out_ready.
   assign stall    = out_valid_q && !out_ready;
   assign in_ready = !stall;

   // Stage k adds segment k. Its inputs are the ports (k = 0) or the register
   // of stage k-1. Operand bits still to be added (skew) shrink by one segment
   // per stage and are kept right-aligned, so the current segment is always
   // at [SEG-1:0]; finished sum bits (deskew) grow by one segment per stage.
   genvar k;
   for (k = 0; k < STAGES; k++) begin : g_stage
      localparam int RW = WIDTH - k * SEG;   // operand bits not yet added
      localparam int DW = (k + 1) * SEG;     // sum bits known after this stage

      logic          vld_in;
      logic          c_in;
      logic [RW-1:0] a_in;
      logic [RW-1:0] bp_in;
      logic [DW-1:0] s_out;
      logic [SEG:0]  seg_sum;

      if (k == 0) begin : g_src
         assign vld_in = in_valid;
         assign c_in   = sub;            // +1 completes the two's-complement of b
         assign a_in   = a;
         assign bp_in  = sub ? ~b : b;
         assign s_out  = seg_sum[SEG-1:0];
      end else begin : g_src
         assign vld_in = g_stage[k-1].g_reg.vld_q;
         assign c_in   = g_stage[k-1].g_reg.c_q;
         assign a_in   = g_stage[k-1].g_reg.a_q;
         assign bp_in  = g_stage[k-1].g_reg.bp_q;
         assign s_out  = {seg_sum[SEG-1:0], g_stage[k-1].g_reg.s_q};
      end

      assign seg_sum = {1'b0, a_in[SEG-1:0]} + {1'b0, bp_in[SEG-1:0]} + {{SEG{1'b0}}, c_in};

      if (k < STAGES - 1) begin : g_reg
         logic             vld_q;
         logic             c_q;
         logic [RW-SEG-1:0] a_q;
         logic [RW-SEG-1:0] bp_q;
         logic [DW-1:0]    s_q;

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               vld_q <= 1'b0;
            end else if (!stall) begin
               vld_q <= vld_in;
            end
         end

         // Datapath carries no reset; only the valid bit qualifies it.
         always_ff @(posedge clk) begin
            if (!stall) begin
               c_q  <= seg_sum[SEG];
               a_q  <= a_in[RW-1:SEG];
               bp_q <= bp_in[RW-1:SEG];
               s_q  <= s_out;
            end
         end
      end else begin : g_last
         assign last_vld    = vld_in;
         assign last_c      = seg_sum[SEG];
         assign last_sum    = s_out;
         assign last_a_msb  = a_in[RW-1];
         assign last_bp_msb = bp_in[RW-1];
      end
   end

   // Same-sign operands giving a result of the other sign.
   assign overflow_d = (last_a_msb == last_bp_msb) && (last_sum[WIDTH-1] != last_a_msb);

`ifdef ADDSUB_SATURATE_EN
   // Overflow direction follows the sign of a: positive a can only overflow upward.
   assign sum_d = !overflow_d ? last_sum
                : last_a_msb  ? {1'b1, {(WIDTH-1){1'b0}}}
                              : {1'b0, {(WIDTH-1){1'b1}}};
`else
   assign sum_d = last_sum;
`endif

   // Output register doubles as the last pipeline boundary. Result fields load
   // only with a valid result so they read zero until the first one arrives.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid_q <= 1'b0;
         sum_q       <= '0;
         cout_q      <= 1'b0;
         overflow_q  <= 1'b0;
      end else if (!stall) begin
         out_valid_q <= last_vld;
         if (last_vld) begin
            sum_q      <= sum_d;
            cout_q     <= last_c;
            overflow_q <= overflow_d;
         end
      end
   end

   assign out_valid = out_valid_q;
   assign sum       = sum_q;
   assign cout      = cout_q;
   assign overflow  = overflow_q;

endmodule

// File: tb/tb_pipelined_add_sub.sv
// Bench for pipelined_add_sub: a WIDTH=32/STAGES=4 instance (vector table,
// backpressure, random traffic, mid-flight reset) and a WIDTH=8/STAGES=1
// instance (random sweep). Results are checked through per-instance scoreboards.

module tb_pipelined_add_sub;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n;

   logic        iv0, ir0, sb0, ov0, or0, co0, of0;
   logic [31:0] a0, b0, s0;
   logic        iv1, ir1, sb1, ov1, or1, co1, of1;
   logic [7:0]  a1, b1, s1;

   pipelined_add_sub #(.WIDTH(32), .STAGES(4)) u_dut0 (
      .clk(clk), .rst_n(rst_n),
      .in_valid(iv0), .in_ready(ir0), .a(a0), .b(b0), .sub(sb0),
      .out_valid(ov0), .out_ready(or0), .sum(s0), .cout(co0), .overflow(of0)
   );

   pipelined_add_sub #(.WIDTH(8), .STAGES(1)) u_dut1 (
      .clk(clk), .rst_n(rst_n),
      .in_valid(iv1), .in_ready(ir1), .a(a1), .b(b1), .sub(sb1),
      .out_valid(ov1), .out_ready(or1), .sum(s1), .cout(co1), .overflow(of1)
   );

   typedef struct packed {
      logic [31:0] sum;
      logic        cout;
      logic        ovf;
   } res_t;

   typedef struct {
      res_t r;
      int   cyc;
      int   stl;
   } sb_t;

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic        sub;
      logic [31:0] sum;
      logic [31:0] sat_sum;
      logic        cout;
      logic        ovf;
   } vec_t;

   sb_t  q0[$];
   sb_t  q1[$];
   int   n_cmp = 0;
   int   n_err = 0;
   int   cyc   = 0;
   int   stl0  = 0;
   int   stl1  = 0;
   res_t e0, e1;
   logic acc0, acc1;
   logic hold0, hold1;
   logic [31:0] hs0, hs1;
   logic hc0, hf0, hc1, hf1;

   // Reference: integer arithmetic on sign-extended / zero-extended values.
   function automatic res_t model(int w, logic [31:0] a, logic [31:0] b, logic s);
      longint m  = longint'(1) << w;
      longint ua = longint'(a);
      longint ub = longint'(b);
      longint sa = (ua >= m / 2) ? ua - m : ua;
      longint sb = (ub >= m / 2) ? ub - m : ub;
      longint r  = s ? sa - sb : sa + sb;
      longint u  = s ? ua - ub : ua + ub;
      res_t   x;
      x.ovf  = (r >= m / 2) || (r < -(m / 2));
      x.cout = s ? (ua >= ub) : (u >= m);
      x.sum  = 32'(u & (m - 1));
`ifdef ADDSUB_SATURATE_EN
      if (x.ovf) x.sum = 32'((r > 0) ? (m / 2 - 1) : (m / 2));
`endif
      return x;
   endfunction

   task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
      end
   endtask

   // One clock: sample both handshakes at the falling edge, then advance.
   task automatic tick();
      @(negedge clk);
      acc0 = rst_n && iv0 && ir0;
      acc1 = rst_n && iv1 && ir1;
      if (!rst_n) begin
         hold0 = 1'b0;
         hold1 = 1'b0;
      end else begin
         if (hold0) begin
            chk("hold0_vld", 32'(ov0), 32'd1);
            chk("hold0_sum", s0, hs0);
            chk("hold0_cout", 32'(co0), 32'(hc0));
            chk("hold0_ovf", 32'(of0), 32'(hf0));
         end
         hold0 = ov0 && !or0;
         hs0 = s0; hc0 = co0; hf0 = of0;
         if (hold0) chk("stall0_in_ready", 32'(ir0), 32'd0);
         if (ov0 && or0) begin
            if (q0.size() == 0) begin
               n_cmp++; n_err++;
               $display("FAIL out0_unexpected: got sum 0x%0h, expected no output", s0);
            end else begin
               sb_t x;
               x = q0.pop_front();
               chk("sum0", s0, x.r.sum);
               chk("cout0", 32'(co0), 32'(x.r.cout));
               chk("ovf0", 32'(of0), 32'(x.r.ovf));
               chk("lat0", 32'(cyc - x.cyc), 32'(4 + stl0 - x.stl));
            end
         end
         if (acc0) q0.push_back('{e0, cyc, stl0});
         if (hold0) stl0++;

         if (hold1) begin
            chk("hold1_vld", 32'(ov1), 32'd1);
            chk("hold1_sum", {24'd0, s1}, hs1);
            chk("hold1_cout", 32'(co1), 32'(hc1));
            chk("hold1_ovf", 32'(of1), 32'(hf1));
         end
         hold1 = ov1 && !or1;
         hs1 = {24'd0, s1}; hc1 = co1; hf1 = of1;
         if (hold1) chk("stall1_in_ready", 32'(ir1), 32'd0);
         if (ov1 && or1) begin
            if (q1.size() == 0) begin
               n_cmp++; n_err++;
               $display("FAIL out1_unexpected: got sum 0x%0h, expected no output", s1);
            end else begin
               sb_t x;
               x = q1.pop_front();
               chk("sum1", {24'd0, s1}, x.r.sum);
               chk("cout1", 32'(co1), 32'(x.r.cout));
               chk("ovf1", 32'(of1), 32'(x.r.ovf));
               chk("lat1", 32'(cyc - x.cyc), 32'(1 + stl1 - x.stl));
            end
         end
         if (acc1) q1.push_back('{e1, cyc, stl1});
         if (hold1) stl1++;
      end
      @(posedge clk);
      cyc++;
      #1;
   endtask

   task automatic drain(string nm);
      iv0 = 1'b0; iv1 = 1'b0; or0 = 1'b1; or1 = 1'b1;
      for (int c = 0; c < 50 && (q0.size() != 0 || q1.size() != 0); c++) tick();
      chk({nm, "_q0_empty"}, 32'(q0.size()), 32'd0);
      chk({nm, "_q1_empty"}, 32'(q1.size()), 32'd0);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      vec_t tbl[10];
      int   i;
      int   st;
      int   n_acc;
      logic st_done;

      tbl[0] = '{32'hFFFFFFFF, 32'h00000001, 1'b0, 32'h00000000, 32'h00000000, 1'b1, 1'b0};
      tbl[1] = '{32'h00000005, 32'h00000007, 1'b1, 32'hFFFFFFFE, 32'hFFFFFFFE, 1'b0, 1'b0};
      tbl[2] = '{32'h7FFFFFFF, 32'h00000001, 1'b0, 32'h80000000, 32'h7FFFFFFF, 1'b0, 1'b1};
      tbl[3] = '{32'h80000000, 32'h00000001, 1'b1, 32'h7FFFFFFF, 32'h80000000, 1'b1, 1'b1};
      tbl[4] = '{32'h00000007, 32'h00000005, 1'b1, 32'h00000002, 32'h00000002, 1'b1, 1'b0};
      tbl[5] = '{32'h00000000, 32'h00000000, 1'b1, 32'h00000000, 32'h00000000, 1'b1, 1'b0};
      tbl[6] = '{32'h0000FFFF, 32'h00000001, 1'b0, 32'h00010000, 32'h00010000, 1'b0, 1'b0};
      tbl[7] = '{32'h12345678, 32'h0FEDCBA9, 1'b0, 32'h22222221, 32'h22222221, 1'b0, 1'b0};
      tbl[8] = '{32'h80000000, 32'h80000000, 1'b0, 32'h00000000, 32'h80000000, 1'b1, 1'b1};
      tbl[9] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 32'h00000000, 32'h00000000, 1'b1, 1'b0};

      rst_n = 1'b0;
      iv0 = 1'b0; a0 = '0; b0 = '0; sb0 = 1'b0; or0 = 1'b1;
      iv1 = 1'b0; a1 = '0; b1 = '0; sb1 = 1'b0; or1 = 1'b1;
      hold0 = 1'b0; hold1 = 1'b0; e0 = '0; e1 = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_out_valid0", 32'(ov0), 32'd0);
      chk("rst_sum0", s0, 32'd0);
      chk("rst_cout0", 32'(co0), 32'd0);
      chk("rst_ovf0", 32'(of0), 32'd0);
      chk("rst_out_valid1", 32'(ov1), 32'd0);
      chk("rst_sum1", {24'd0, s1}, 32'd0);
      rst_n = 1'b1;
      chk("rel_in_ready0", 32'(ir0), 32'd1);
      chk("rel_in_ready1", 32'(ir1), 32'd1);
      tick();

      // Directed vectors, back to back.
      for (int v = 0; v < 10; v++) begin
         iv0 = 1'b1; a0 = tbl[v].a; b0 = tbl[v].b; sb0 = tbl[v].sub;
`ifdef ADDSUB_SATURATE_EN
         e0.sum = tbl[v].sat_sum;
`else
         e0.sum = tbl[v].sum;
`endif
         e0.cout = tbl[v].cout;
         e0.ovf  = tbl[v].ovf;
         tick();
         chk("tbl_accept", 32'(acc0), 32'd1);
      end
      drain("tbl");

      // Six-op stream with a three-cycle output stall once results appear.
      i = 0; st = 0; st_done = 1'b0;
      for (int c = 0; c < 60 && !(i == 6 && q0.size() == 0); c++) begin
         iv0 = (i < 6); a0 = 32'(i + 16); b0 = 32'(i); sb0 = i[0];
         e0  = model(32, a0, b0, sb0);
         if (!st_done && ov0) begin
            or0 = 1'b0;
            st++;
            if (st == 3) st_done = 1'b1;
         end else begin
            or0 = 1'b1;
         end
         tick();
         if (acc0) i++;
      end
      chk("bp_accepted", 32'(i), 32'd6);
      chk("bp_stall_cycles", 32'(st), 32'd3);
      drain("bp");

      // Random traffic on the 4-stage instance.
      for (int c = 0; c < 300; c++) begin
         iv0 = ($urandom_range(0, 3) != 0);
         a0  = $urandom; b0 = $urandom; sb0 = 1'($urandom);
         or0 = ($urandom_range(0, 3) != 0);
         e0  = model(32, a0, b0, sb0);
         tick();
      end
      drain("rnd0");

      // Reset with three operations in flight, before any reaches the output.
      for (int j = 0; j < 3; j++) begin
         iv0 = 1'b1; a0 = 32'(j + 100); b0 = 32'(j); sb0 = 1'b0;
         e0  = model(32, a0, b0, sb0);
         tick();
         chk("rm_accept", 32'(acc0), 32'd1);
      end
      iv0 = 1'b0;
      rst_n = 1'b0;
      #1;
      chk("rm_out_valid", 32'(ov0), 32'd0);
      chk("rm_sum", s0, 32'd0);
      q0.delete();
      q1.delete();
      tick();
      rst_n = 1'b1;
      chk("rm_in_ready", 32'(ir0), 32'd1);
      repeat (6) tick();
      iv0 = 1'b1; a0 = 32'h0000ABCD; b0 = 32'h00001234; sb0 = 1'b1;
      e0  = model(32, a0, b0, sb0);
      tick();
      chk("rm_new_accept", 32'(acc0), 32'd1);
      drain("rm");

      // STAGES=1 random sweep.
      n_acc = 0;
      for (int c = 0; c < 5000 && n_acc < 1000; c++) begin
         iv1 = ($urandom_range(0, 3) != 0);
         a1  = 8'($urandom); b1 = 8'($urandom); sb1 = 1'($urandom);
         or1 = ($urandom_range(0, 3) != 0);
         e1  = model(8, {24'd0, a1}, {24'd0, b1}, sb1);
         tick();
         if (acc1) n_acc++;
      end
      chk("sweep1_count", 32'(n_acc), 32'd1000);
      drain("sweep1");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
